// File: rtl/flg_encoder_pkg.sv
// ============================================================================
// Module      : flg_encoder_pkg
// Description : Shared parameter defaults and state encoding for flg_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef C_LOG_2
`define C_LOG_2(x) $clog2(x)
`endif

package flg_encoder_pkg;

  localparam int DW_DATA_WIDTH = 32;
  localparam int DW_ACT_WIDTH  = 8;

  localparam logic [0:0] S_COLL = 1'b0;
  localparam logic [0:0] S_FLAG = 1'b1;

endpackage

`default_nettype wire

// File: rtl/flg_encoder.sv
// ============================================================================
// Module      : flg_encoder
// Description : Dense-to-sparse activation compressor emitting packed nonzero
//               values plus a per-group flag word and nonzero count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef C_LOG_2
`define C_LOG_2(x) $clog2(x)
`endif

module flg_encoder
  import flg_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DATA_WIDTH,
  parameter int ACT_WIDTH  = DW_ACT_WIDTH,
  parameter int CNT_WIDTH  = `C_LOG_2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  I_Clr,
  input  logic                  I_Val,
  input  logic [ACT_WIDTH-1:0]  I_Data,
  output logic                  I_Rdy,
  output logic                  O_Dat_Val,
  output logic [ACT_WIDTH-1:0]  O_Dat,
  input  logic                  O_Dat_Rdy,
  output logic                  O_Flag_Val,
  output logic [DATA_WIDTH-1:0] O_Flag,
  output logic [CNT_WIDTH-1:0]  O_Cnt,
  input  logic                  O_Flag_Rdy
);

  localparam logic [DATA_WIDTH-1:0] c_MSB     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  c_LAST_CH = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [0:0]            r_state;
  logic [0:0]            w_stateNext;
  logic [CNT_WIDTH-1:0]  r_chCnt;
  logic [CNT_WIDTH-1:0]  r_nzCnt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  w_accept;
  logic                  w_nz;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_flagBit;
  logic [CNT_WIDTH-1:0]  w_nzInc;

  assign w_accept  = I_Val && I_Rdy;
  assign w_nz      = |I_Data;
  assign w_last    = (r_chCnt == c_LAST_CH);
  // ch0 lands in the MSB, so the flag bit walks down from the top.
  assign w_flagBit = w_nz ? (c_MSB >> r_chCnt) : '0;
  assign w_nzInc   = {{(CNT_WIDTH-1){1'b0}}, w_nz};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLL;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (I_Clr) begin
      w_stateNext = S_COLL;
    end else begin
      case (r_state)
        S_COLL:  if (w_accept && w_last)         w_stateNext = S_FLAG;
        S_FLAG:  if (O_Flag_Val && O_Flag_Rdy)   w_stateNext = S_COLL;
        default: w_stateNext = S_COLL;
      endcase
    end
  end

  always_comb begin
    I_Rdy = (r_state == S_COLL) && !I_Clr && (!O_Dat_Val || O_Dat_Rdy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chCnt <= '0;
      r_nzCnt <= '0;
      r_acc   <= '0;
    end else if (I_Clr) begin
      r_chCnt <= '0;
      r_nzCnt <= '0;
      r_acc   <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_chCnt <= '0;
        r_nzCnt <= '0;
        r_acc   <= '0;
      end else begin
        r_chCnt <= r_chCnt + 1'b1;
        r_nzCnt <= r_nzCnt + w_nzInc;
        r_acc   <= r_acc | w_flagBit;
      end
    end
  end

  // A reload on a simultaneous consume keeps the valid high for 1 beat/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O_Dat_Val <= 1'b0;
      O_Dat     <= '0;
    end else if (I_Clr) begin
      O_Dat_Val <= 1'b0;
    end else if (w_accept && w_nz) begin
      O_Dat_Val <= 1'b1;
      O_Dat     <= I_Data;
    end else if (O_Dat_Val && O_Dat_Rdy) begin
      O_Dat_Val <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O_Flag_Val <= 1'b0;
      O_Flag     <= '0;
      O_Cnt      <= '0;
    end else if (I_Clr) begin
      O_Flag_Val <= 1'b0;
    end else if (w_accept && w_last) begin
      O_Flag_Val <= 1'b1;
      O_Flag     <= r_acc | w_flagBit;
      O_Cnt      <= r_nzCnt + w_nzInc;
    end else if (O_Flag_Val && O_Flag_Rdy) begin
      O_Flag_Val <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flg_encoder.sv
// ============================================================================
// Module      : tb_flg_encoder
// Description : Directed self-checking bench for flg_encoder with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flg_encoder;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 6;

  logic          clk;
  logic          rst_n;
  logic          I_Clr;
  logic          I_Val;
  logic [AW-1:0] I_Data;
  logic          I_Rdy;
  logic          O_Dat_Val;
  logic [AW-1:0] O_Dat;
  logic          O_Dat_Rdy;
  logic          O_Flag_Val;
  logic [DW-1:0] O_Flag;
  logic [CW-1:0] O_Cnt;
  logic          O_Flag_Rdy;

  flg_encoder #(.DATA_WIDTH(DW), .ACT_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .I_Clr(I_Clr), .I_Val(I_Val), .I_Data(I_Data),
    .I_Rdy(I_Rdy), .O_Dat_Val(O_Dat_Val), .O_Dat(O_Dat), .O_Dat_Rdy(O_Dat_Rdy),
    .O_Flag_Val(O_Flag_Val), .O_Flag(O_Flag), .O_Cnt(O_Cnt), .O_Flag_Rdy(O_Flag_Rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model: whole-group view of the protocol ----------------
  logic [AW-1:0] dq[$];
  logic [DW-1:0] fqFlag[$];
  int            fqCnt[$];
  logic [AW-1:0] grp[DW];
  int            gi = 0;
  int            beatCnt = 0;
  int            rdyLowCnt = 0;
  logic [DW-1:0] lastFlag = '0;
  int            lastCnt = -1;
  logic [AW-1:0] lastBeat = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dq.delete(); fqFlag.delete(); fqCnt.delete(); gi = 0;
    end else begin
      logic expRdy;
      expRdy = (fqFlag.size() == 0) && !I_Clr && (dq.size() == 0 || O_Dat_Rdy);
      chk("I_Rdy", I_Rdy, expRdy);
      chk("O_Dat_Val", O_Dat_Val, dq.size() != 0);
      if (dq.size() != 0) chk("O_Dat", O_Dat, dq[0]);
      chk("O_Flag_Val", O_Flag_Val, fqFlag.size() != 0);
      if (fqFlag.size() != 0) begin
        chk("O_Flag", O_Flag, fqFlag[0]);
        chk("O_Cnt", O_Cnt, fqCnt[0]);
      end
      if (!I_Rdy) rdyLowCnt++;

      if (I_Clr) begin
        dq.delete(); fqFlag.delete(); fqCnt.delete(); gi = 0;
      end else begin
        if (O_Dat_Val && O_Dat_Rdy && dq.size() != 0) begin
          beatCnt++; lastBeat = dq.pop_front();
        end
        if (O_Flag_Val && O_Flag_Rdy && fqFlag.size() != 0) begin
          lastFlag = fqFlag.pop_front(); lastCnt = fqCnt.pop_front();
        end
        if (I_Val && I_Rdy) begin
          grp[gi] = I_Data;
          if (I_Data != 0) dq.push_back(I_Data);
          gi++;
          if (gi == DW) begin
            logic [DW-1:0] f;
            int n;
            f = '0; n = 0;
            for (int k = 0; k < DW; k++)
              if (grp[k] != 0) begin f[DW-1-k] = 1'b1; n++; end
            fqFlag.push_back(f); fqCnt.push_back(n); gi = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sendCh(input logic [AW-1:0] v);
    int n;
    n = 0;
    I_Val = 1'b1; I_Data = v;
    @(negedge clk);
    while (!I_Rdy && n < 200) begin n++; @(negedge clk); end
    if (!I_Rdy) chk("sendCh_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
    I_Val = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while ((O_Flag_Val || O_Dat_Val || !I_Rdy) && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) chk("waitIdle_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic startTest();
    beatCnt = 0; rdyLowCnt = 0; lastCnt = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; I_Clr = 1'b0; I_Val = 1'b0; I_Data = '0;
    O_Dat_Rdy = 1'b1; O_Flag_Rdy = 1'b1;
    #1;
    chk("rst_O_Dat_Val", O_Dat_Val, 1'b0);
    chk("rst_O_Flag_Val", O_Flag_Val, 1'b0);
    chk("rst_O_Flag", O_Flag, '0);
    chk("rst_O_Cnt", O_Cnt, '0);
    chk("rst_O_Dat", O_Dat, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: {5,0,0,7, zeros}
    startTest();
    for (int k = 0; k < DW; k++) sendCh(k == 0 ? 8'd5 : (k == 3 ? 8'd7 : 8'd0));
    waitIdle();
    chk("t1_flag", lastFlag, 32'h9000_0000);
    chk("t1_cnt", lastCnt, 2);
    chk("t1_beats", beatCnt, 2);
    chk("t1_lastBeat", lastBeat, 8'd7);
    chk("t1_rdyLow", rdyLowCnt, 1);

    // 2a: all zero
    startTest();
    for (int k = 0; k < DW; k++) sendCh(8'd0);
    waitIdle();
    chk("t2a_flag", lastFlag, 32'h0);
    chk("t2a_cnt", lastCnt, 0);
    chk("t2a_beats", beatCnt, 0);

    // 2b: values 1..32
    startTest();
    for (int k = 0; k < DW; k++) sendCh(AW'(k + 1));
    waitIdle();
    chk("t2b_flag", lastFlag, 32'hFFFF_FFFF);
    chk("t2b_cnt", lastCnt, 32);
    chk("t2b_beats", beatCnt, 32);
    chk("t2b_lastBeat", lastBeat, 8'd32);

    // 3: alternating 0x11 with a 3-cycle data stall at ch4
    startTest();
    for (int k = 0; k < DW; k++) begin
      if (k == 4) begin
        O_Dat_Rdy = 1'b0;
        fork
          begin repeat (3) @(posedge clk); #1 O_Dat_Rdy = 1'b1; end
        join_none
      end
      sendCh(k % 2 == 0 ? 8'h11 : 8'h00);
    end
    waitIdle();
    chk("t3_flag", lastFlag, 32'hAAAA_AAAA);
    chk("t3_cnt", lastCnt, 16);
    chk("t3_beats", beatCnt, 16);
    chk("t3_stallSeen", rdyLowCnt >= 3, 1'b1);

    // 4: flag consumer stalled 10 cycles
    startTest();
    for (int k = 0; k < DW; k++) begin
      if (k == DW - 1) O_Flag_Rdy = 1'b0;
      sendCh(k < 4 ? 8'hC3 : 8'h00);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t4_hold_val", O_Flag_Val, 1'b1);
      chk("t4_hold_flag", O_Flag, 32'hF000_0000);
      chk("t4_hold_rdy", I_Rdy, 1'b0);
    end
    @(posedge clk); #1 O_Flag_Rdy = 1'b1;
    sendCh(8'd0);
    chk("t4_cnt", lastCnt, 4);
    chk("t4_retain_flag", O_Flag, 32'hF000_0000);
    for (int k = 1; k < DW; k++) sendCh(8'd0);
    waitIdle();

    // 5: clear at ch10 with a pending data beat
    startTest();
    for (int k = 0; k < 10; k++) sendCh(8'd3);
    O_Dat_Rdy = 1'b0; I_Clr = 1'b1;
    @(negedge clk);
    chk("t5_pending", O_Dat_Val, 1'b1);
    @(posedge clk); #1;
    I_Clr = 1'b0; O_Dat_Rdy = 1'b1;
    chk("t5_clr_datval", O_Dat_Val, 1'b0);
    chk("t5_clr_retain", O_Dat, 8'd3);
    startTest();
    for (int k = 0; k < DW; k++) sendCh(8'd3);
    waitIdle();
    chk("t5_flag", lastFlag, 32'hFFFF_FFFF);
    chk("t5_cnt", lastCnt, 32);
    chk("t5_beats", beatCnt, 32);

    // 6: async reset mid-group at ch20
    for (int k = 0; k < 20; k++) sendCh(AW'(k));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_datval", O_Dat_Val, 1'b0);
    chk("t6_rst_dat", O_Dat, '0);
    chk("t6_rst_flag", O_Flag, '0);
    chk("t6_rst_cnt", O_Cnt, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    startTest();
    for (int k = 0; k < DW; k++) sendCh(k == DW - 1 ? 8'd9 : 8'd0);
    waitIdle();
    chk("t6_flag", lastFlag, 32'h0000_0001);
    chk("t6_cnt", lastCnt, 1);
    chk("t6_beats", beatCnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
